// File: rtl/ps2_pkg.sv
// Shared constants and entry layout for the PS/2 receive path.
// Frame bit positions, prefix codes and the {ext,brk,code} FIFO entry.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int BIT_START = 0;
    localparam int BIT_D0    = 1;
    localparam int BIT_D7    = 8;
    localparam int BIT_PAR   = 9;
    localparam int BIT_STOP  = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    localparam int ENTRY_W = $bits(ps2_entry_t);

    // Start low, stop high, odd parity over data+parity.
    function automatic logic frame_ok(input logic [BIT_PAR:0] f, input logic stop);
        return (f[BIT_START] == 1'b0) && stop && (^f[BIT_PAR:BIT_D0]);
    endfunction
endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO; head word is visible on o_dout whenever !o_empty.
// A push on a full FIFO is taken only when a pop frees the slot in the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_rd;
    logic             w_wr;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LVL_FULL);
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter, 11-bit deframer with
// watchdog, E0/F0 prefix folding and a buffered valid/ready event port.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int DECODE      = 1,
    parameter int CNT_W       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_clr,
    input  logic                   i_ps2_clk,
    input  logic                   i_ps2_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [7:0]             o_out_code,
    output logic                   o_out_ext,
    output logic                   o_out_brk,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic                   o_err_frame,
    output logic                   o_err_timeout,
    output logic [CNT_W-1:0]       o_brk_cnt
);
    localparam int FCW = $clog2(FILT_LEN+1);
    localparam int WDW = $clog2(TIMEOUT_CYC+1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_clk_s;
    logic                   w_dat_s;

    logic                   r_filt_lvl;
    logic [FCW-1:0]         r_filt_cnt;
    logic                   w_flip;
    logic                   w_strobe;

    logic [3:0]             r_bitcnt;
    logic [BIT_PAR:0]       r_frame;
    logic [WDW-1:0]         r_wd;
    logic                   r_rx_vld;
    logic [7:0]             r_rx_byte;
    logic                   r_err_frame;
    logic                   r_err_timeout;

    logic                   r_ext_pend;
    logic                   r_brk_pend;
    logic                   w_is_ext;
    logic                   w_is_brk;
    logic                   w_push;
    ps2_entry_t             w_entry;

    logic [ENTRY_W-1:0]     w_dout;
    ps2_entry_t             w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   r_overflow;
    logic [CNT_W-1:0]       r_brk_cnt;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
    assign w_flip   = (w_clk_s != r_filt_lvl) && (r_filt_cnt == FCW'(FILT_LEN-1));
    assign w_strobe = w_flip && r_filt_lvl;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_filt_lvl <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_lvl) begin
            r_filt_cnt <= '0;
        end else if (w_flip) begin
            r_filt_lvl <= ~r_filt_lvl;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // Deframer and watchdog share the strobe; the watchdog only runs mid-frame.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_bitcnt      <= '0;
            r_frame       <= '0;
            r_wd          <= '0;
            r_rx_vld      <= 1'b0;
            r_rx_byte     <= '0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_rx_vld      <= 1'b0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_strobe) begin
                r_wd <= '0;
                if (r_bitcnt == 4'(BIT_STOP)) begin
                    r_bitcnt <= '0;
                    if (frame_ok(r_frame, w_dat_s)) begin
                        r_rx_vld  <= 1'b1;
                        r_rx_byte <= r_frame[BIT_D7:BIT_D0];
                    end else begin
                        r_err_frame <= 1'b1;
                    end
                end else begin
                    r_frame[r_bitcnt] <= w_dat_s;
                    r_bitcnt          <= r_bitcnt + 1'b1;
                end
            end else if (r_bitcnt != '0) begin
                if (r_wd == WDW'(TIMEOUT_CYC-1)) begin
                    r_bitcnt      <= '0;
                    r_wd          <= '0;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign w_is_ext = (DECODE != 0) && (r_rx_byte == PS2_EXT);
    assign w_is_brk = (DECODE != 0) && (r_rx_byte == PS2_BRK);
    assign w_push   = r_rx_vld && !w_is_ext && !w_is_brk;
    assign w_entry  = {r_ext_pend, r_brk_pend, r_rx_byte};

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_err_frame || r_err_timeout) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_rx_vld) begin
            if (w_is_ext) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_brk) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    assign w_pop = o_out_valid & i_out_ready;

    ps2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_clr),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_overflow <= 1'b0;
            r_brk_cnt  <= '0;
        end else begin
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (w_push && (!w_full || w_pop) && w_entry.brk)
                r_brk_cnt <= r_brk_cnt + 1'b1;
        end
    end

    assign w_head        = w_dout;
    assign o_out_valid   = ~w_empty;
    assign o_out_code    = o_out_valid ? w_head.code : 8'h00;
    assign o_out_ext     = o_out_valid & w_head.ext;
    assign o_out_brk     = o_out_valid & w_head.brk;
    assign o_overflow    = r_overflow;
    assign o_err_frame   = r_err_frame;
    assign o_err_timeout = r_err_timeout;
    assign o_brk_cnt     = r_brk_cnt;
endmodule
